// File: rtl/control_unit.sv
// control_unit: Moore fetch/decode/execute sequencer driving the register-bus datapath strobes.
module control_unit #(
  parameter int STALL_LIMIT = 15
) (
  input  logic        clk,
  input  logic        clear,
  input  logic [31:0] IR,
  input  logic        con_ff,
  input  logic        mem_ready,
  output logic        PCout, MDRout, HIout, LOout, Zhighout, Zlowout, Cout, BAout,
  output logic        PCin, IRin, MARin, Yin, HIin, LOin, Zin, MDRin,
  output logic        Gra, Grb, Grc, Rin, Rout,
  output logic        AND, OR, ADD, SUB, MUL, DIV, SHR, SHL, ROR, ROL, NEG, NOT, IncPC,
  output logic        read, write,
  output logic        run,
  output logic        mem_err,
  output logic        illegal_op
);
  localparam int CW = $clog2(STALL_LIMIT + 1);
  localparam logic [4:0] OP_LD = 5'd0, OP_LDI = 5'd1, OP_ST = 5'd2, OP_ADD = 5'd3, OP_SUB = 5'd4,
    OP_AND = 5'd5, OP_OR = 5'd6, OP_SHR = 5'd7, OP_SHL = 5'd8, OP_ROR = 5'd9, OP_ROL = 5'd10,
    OP_ADDI = 5'd11, OP_ANDI = 5'd12, OP_ORI = 5'd13, OP_MUL = 5'd14, OP_DIV = 5'd15,
    OP_NEG = 5'd16, OP_NOT = 5'd17, OP_BR = 5'd18, OP_JR = 5'd19, OP_MFHI = 5'd23,
    OP_MFLO = 5'd24, OP_NOP = 5'd25, OP_HALT = 5'd26;
  typedef enum logic [3:0] {RESET, T0, T1, T2, T3, T4, T5, T6, T7, HALT} state_t;
  state_t state, next;
  logic [4:0] opc, d;
  logic [CW-1:0] cnt;
  logic con, legal, wait_st, stall_out, unused_ir;
  logic alu, imm, ld, ldi, st, md, nn, br, jr, mfhi, mflo;
  assign d = IR[31:27];
  assign unused_ir = ^IR[26:0];
  assign legal = d <= OP_JR || (d >= OP_MFHI && d <= OP_HALT);
  assign alu = opc >= OP_ADD && opc <= OP_ROL;
  assign imm = opc >= OP_ADDI && opc <= OP_ORI;
  assign ld = opc == OP_LD;
  assign ldi = opc == OP_LDI;
  assign st = opc == OP_ST;
  assign md = opc == OP_MUL || opc == OP_DIV;
  assign nn = opc == OP_NEG || opc == OP_NOT;
  assign br = opc == OP_BR;
  assign jr = opc == OP_JR;
  assign mfhi = opc == OP_MFHI;
  assign mflo = opc == OP_MFLO;
  // memory handshake states hold until mem_ready, bounded by the stall counter
  assign wait_st = state == T1 || (state == T6 && ld) || (state == T7 && st);
  assign stall_out = !mem_ready && cnt == CW'(STALL_LIMIT - 1);
  assign run = state != HALT;
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      state <= RESET;
      cnt <= '0;
      con <= 1'b0;
      opc <= '0;
      mem_err <= 1'b0;
      illegal_op <= 1'b0;
    end else begin
      state <= next;
      cnt <= (wait_st && !mem_ready) ? cnt + 1'b1 : '0;
      if (state == T2) opc <= d;
      if (state == T3 && br) con <= con_ff;
      if (wait_st && stall_out) mem_err <= 1'b1;
      if (state == T2 && !legal) illegal_op <= 1'b1;
    end
  end
  always_comb begin
    next = state;
    case (state)
      RESET: next = T0;
      T0: next = T1;
      T1: next = T2;
      T2: next = d == OP_NOP ? T0 : (d == OP_HALT || !legal) ? HALT : T3;
      T3: next = (jr || mfhi || mflo) ? T0 : T4;
      T4: next = nn ? T0 : T5;
      T5: next = (alu || imm || ldi) ? T0 : T6;
      T6: next = (md || br) ? T0 : T7;
      T7: next = T0;
      default: next = HALT;
    endcase
    if (wait_st && !mem_ready) next = stall_out ? HALT : state;
  end
  always_comb begin
    {PCout, MDRout, HIout, LOout, Zhighout, Zlowout, Cout, BAout, PCin, IRin, MARin, Yin, HIin,
     LOin, Zin, MDRin, Gra, Grb, Grc, Rin, Rout, AND, OR, ADD, SUB, MUL, DIV, SHR, SHL, ROR, ROL,
     NEG, NOT, IncPC, read, write} = '0;
    case (state)
      T0: {PCout, MARin, IncPC, Zin} = '1;
      T1: {Zlowout, PCin, read, MDRin} = '1;
      T2: {MDRout, IRin} = '1;
      T3: begin
        Grb = alu | imm | ld | ldi | st | nn;
        Gra = md | br | jr | mfhi | mflo;
        Rout = alu | imm | md | nn | br | jr;
        BAout = ld | ldi | st;
        Yin = alu | imm | ld | ldi | st | md;
        Zin = nn;
        NEG = opc == OP_NEG;
        NOT = opc == OP_NOT;
        PCin = jr;
        HIout = mfhi;
        LOout = mflo;
        Rin = mfhi | mflo;
      end
      T4: begin
        Grc = alu;
        Cout = imm | ld | ldi | st;
        Grb = md;
        Rout = alu | md;
        Zin = alu | imm | ld | ldi | st | md;
        ADD = opc == OP_ADD || opc == OP_ADDI || ld || ldi || st;
        SUB = opc == OP_SUB;
        AND = opc == OP_AND || opc == OP_ANDI;
        OR = opc == OP_OR || opc == OP_ORI;
        SHR = opc == OP_SHR;
        SHL = opc == OP_SHL;
        ROR = opc == OP_ROR;
        ROL = opc == OP_ROL;
        MUL = opc == OP_MUL;
        DIV = opc == OP_DIV;
        Zlowout = nn;
        Gra = nn;
        Rin = nn;
        PCout = br;
        Yin = br;
      end
      T5: begin
        Zlowout = alu | imm | ldi | ld | st | md;
        Gra = alu | imm | ldi;
        Rin = alu | imm | ldi;
        MARin = ld | st;
        LOin = md;
        Cout = br;
        ADD = br;
        Zin = br;
      end
      T6: begin
        read = ld;
        MDRin = ld | st;
        Gra = st;
        Rout = st;
        Zhighout = md;
        HIin = md;
        Zlowout = br & con;
        PCin = br & con;
      end
      T7: begin
        MDRout = ld;
        Gra = ld;
        Rin = ld;
        write = st;
      end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit: scoreboard bench replaying per-cycle expected strobe vectors against control_unit.
module tb_control_unit;
  typedef logic [38:0] vec_t;
  localparam vec_t PCO = vec_t'(1) << 38, MDRO = vec_t'(1) << 37, HIO = vec_t'(1) << 36,
    LOO = vec_t'(1) << 35, ZHO = vec_t'(1) << 34, ZLO = vec_t'(1) << 33, CO = vec_t'(1) << 32,
    BAO = vec_t'(1) << 31, PCI = vec_t'(1) << 30, IRI = vec_t'(1) << 29, MARI = vec_t'(1) << 28,
    YI = vec_t'(1) << 27, HII = vec_t'(1) << 26, LOI = vec_t'(1) << 25, ZI = vec_t'(1) << 24,
    MDRI = vec_t'(1) << 23, GA = vec_t'(1) << 22, GB = vec_t'(1) << 21, GC = vec_t'(1) << 20,
    RI = vec_t'(1) << 19, RO = vec_t'(1) << 18, AND_ = vec_t'(1) << 17, OR_ = vec_t'(1) << 16,
    ADD_ = vec_t'(1) << 15, SUB_ = vec_t'(1) << 14, MUL_ = vec_t'(1) << 13, DIV_ = vec_t'(1) << 12,
    SHR_ = vec_t'(1) << 11, SHL_ = vec_t'(1) << 10, ROR_ = vec_t'(1) << 9, ROL_ = vec_t'(1) << 8,
    NEG_ = vec_t'(1) << 7, NOT_ = vec_t'(1) << 6, INC = vec_t'(1) << 5, RD = vec_t'(1) << 4,
    WR = vec_t'(1) << 3, R = vec_t'(1) << 2, MERR = vec_t'(1) << 1, ILL = vec_t'(1);
  localparam vec_t F0 = R | PCO | MARI | INC | ZI, F1 = R | ZLO | PCI | RD | MDRI, F2 = R | MDRO | IRI;
  typedef struct {vec_t e; logic mr; logic cf; logic [31:0] ir;} item_t;
  logic clk = 0, clear = 0, con_ff = 0, mem_ready = 1;
  logic [31:0] IR = 0;
  logic PCout, MDRout, HIout, LOout, Zhighout, Zlowout, Cout, BAout;
  logic PCin, IRin, MARin, Yin, HIin, LOin, Zin, MDRin, Gra, Grb, Grc, Rin, Rout;
  logic AND, OR, ADD, SUB, MUL, DIV, SHR, SHL, ROR, ROL, NEG, NOT, IncPC;
  logic read, write, run, mem_err, illegal_op;
  vec_t obs;
  item_t q[$];
  item_t it;
  logic [31:0] pir;
  int checks = 0, errors = 0, k;
  control_unit #(.STALL_LIMIT(15)) dut (
    .clk(clk), .clear(clear), .IR(IR), .con_ff(con_ff), .mem_ready(mem_ready),
    .PCout(PCout), .MDRout(MDRout), .HIout(HIout), .LOout(LOout), .Zhighout(Zhighout),
    .Zlowout(Zlowout), .Cout(Cout), .BAout(BAout), .PCin(PCin), .IRin(IRin), .MARin(MARin),
    .Yin(Yin), .HIin(HIin), .LOin(LOin), .Zin(Zin), .MDRin(MDRin), .Gra(Gra), .Grb(Grb),
    .Grc(Grc), .Rin(Rin), .Rout(Rout), .AND(AND), .OR(OR), .ADD(ADD), .SUB(SUB), .MUL(MUL),
    .DIV(DIV), .SHR(SHR), .SHL(SHL), .ROR(ROR), .ROL(ROL), .NEG(NEG), .NOT(NOT), .IncPC(IncPC),
    .read(read), .write(write), .run(run), .mem_err(mem_err), .illegal_op(illegal_op)
  );
  assign obs = {PCout, MDRout, HIout, LOout, Zhighout, Zlowout, Cout, BAout, PCin, IRin, MARin,
                Yin, HIin, LOin, Zin, MDRin, Gra, Grb, Grc, Rin, Rout, AND, OR, ADD, SUB, MUL, DIV,
                SHR, SHL, ROR, ROL, NEG, NOT, IncPC, read, write, run, mem_err, illegal_op};
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (!clear) begin
      checks++;
      if ($countones({PCout, MDRout, HIout, LOout, Zhighout, Zlowout, Cout, BAout, Rout}) > 1 ||
          $countones({AND, OR, ADD, SUB, MUL, DIV, SHR, SHL, ROR, ROL, NEG, NOT, IncPC}) > 1) begin
        errors++;
        $display("FAIL invariant t=%0t: strobes=%h have more than one bus source or ALU op", $time, obs);
      end
    end
  end
  task automatic push(input vec_t e, input logic mr = 1'b1, input logic cf = 1'b0);
    q.push_back('{e, mr, cf, pir});
  endtask
  task automatic fetch();
    push(F0);
    push(F1);
    push(F2);
  endtask
  task automatic reset_pulse();
    clear = 1;
    mem_ready = 1;
    @(negedge clk);
    clear = 0;
  endtask
  task automatic test_reset();
    #1 clear = 1;
    #1 checks++;
    if (obs !== R) begin errors++; $display("FAIL reset_async: got %h want %h", obs, R); end
    @(negedge clk);
    checks++;
    if (obs !== R) begin errors++; $display("FAIL reset_hold: got %h want %h", obs, R); end
    clear = 0;
  endtask
  task automatic test_add();
    pir = 32'h1989_0000;
    fetch();
    push(R | GB | RO | YI);
    push(R | GC | RO | ADD_ | ZI);
    push(R | ZLO | GA | RI);
    k = 0;
    while (q.size() > 0) begin
      @(negedge clk);
      it = q.pop_front();
      checks++;
      if (obs !== it.e) begin errors++; $display("FAIL add step%0d: got %h want %h", k, obs, it.e); end
      mem_ready = it.mr; con_ff = it.cf; IR = it.ir; k++;
    end
  endtask
  task automatic test_fetch_stall();
    pir = 32'hC800_0000;
    push(F0);
    push(F1, 0);
    push(F1, 0);
    push(F1, 0);
    push(F1, 1);
    push(F2);
    k = 0;
    while (q.size() > 0) begin
      @(negedge clk);
      it = q.pop_front();
      checks++;
      if (obs !== it.e) begin errors++; $display("FAIL fetch_stall step%0d: got %h want %h", k, obs, it.e); end
      mem_ready = it.mr; con_ff = it.cf; IR = it.ir; k++;
    end
  endtask
  task automatic test_br();
    pir = 32'h9000_0000;
    for (int c = 1; c >= 0; c--) begin
      fetch();
      push(R | GA | RO, 1, c[0]);
      push(R | PCO | YI);
      push(R | CO | ADD_ | ZI);
      push(c[0] ? (R | ZLO | PCI) : R);
    end
    k = 0;
    while (q.size() > 0) begin
      @(negedge clk);
      it = q.pop_front();
      checks++;
      if (obs !== it.e) begin errors++; $display("FAIL br step%0d: got %h want %h", k, obs, it.e); end
      mem_ready = it.mr; con_ff = it.cf; IR = it.ir; k++;
    end
  endtask
  task automatic test_back_to_back();
    pir = 32'h2000_0000;
    fetch(); push(R | GB | RO | YI); push(R | GC | RO | SUB_ | ZI); push(R | ZLO | GA | RI);
    pir = 32'h6000_0000;
    fetch(); push(R | GB | RO | YI); push(R | CO | AND_ | ZI); push(R | ZLO | GA | RI);
    pir = 32'h8800_0000;
    fetch(); push(R | GB | RO | NOT_ | ZI); push(R | ZLO | GA | RI);
    pir = 32'h9800_0000;
    fetch(); push(R | GA | RO | PCI);
    pir = 32'hC000_0000;
    fetch(); push(R | LOO | GA | RI);
    pir = 32'h0000_0000;
    fetch(); push(R | GB | BAO | YI); push(R | CO | ADD_ | ZI); push(R | ZLO | MARI, 0);
    push(R | RD | MDRI, 0); push(R | RD | MDRI, 0); push(R | RD | MDRI, 1); push(R | MDRO | GA | RI);
    k = 0;
    while (q.size() > 0) begin
      @(negedge clk);
      it = q.pop_front();
      checks++;
      if (obs !== it.e) begin errors++; $display("FAIL back_to_back step%0d: got %h want %h", k, obs, it.e); end
      mem_ready = it.mr; con_ff = it.cf; IR = it.ir; k++;
    end
  endtask
  task automatic test_mul_illegal();
    pir = 32'h7228_0000;
    fetch(); push(R | GA | RO | YI); push(R | GB | RO | MUL_ | ZI); push(R | ZLO | LOI); push(R | ZHO | HII);
    pir = 32'hF800_0000;
    fetch(); push(ILL); push(ILL);
    k = 0;
    while (q.size() > 0) begin
      @(negedge clk);
      it = q.pop_front();
      checks++;
      if (obs !== it.e) begin errors++; $display("FAIL mul_illegal step%0d: got %h want %h", k, obs, it.e); end
      mem_ready = it.mr; con_ff = it.cf; IR = it.ir; k++;
    end
    reset_pulse();
  endtask
  task automatic test_ld_timeout();
    pir = 32'h0080_0000;
    fetch(); push(R | GB | BAO | YI); push(R | CO | ADD_ | ZI); push(R | ZLO | MARI, 0);
    for (int i = 0; i < 15; i++) push(R | RD | MDRI, 0);
    push(MERR, 0); push(MERR, 0);
    k = 0;
    while (q.size() > 0) begin
      @(negedge clk);
      it = q.pop_front();
      checks++;
      if (obs !== it.e) begin errors++; $display("FAIL ld_timeout step%0d: got %h want %h", k, obs, it.e); end
      mem_ready = it.mr; con_ff = it.cf; IR = it.ir; k++;
    end
    reset_pulse();
  endtask
  task automatic test_clear_store();
    pir = 32'h1000_0000;
    fetch(); push(R | GB | BAO | YI); push(R | CO | ADD_ | ZI); push(R | ZLO | MARI, 0);
    push(R | GA | RO | MDRI, 0); push(R | WR, 0); push(R | WR, 0);
    push(R | WR, 0);
    k = 0;
    while (q.size() > 0) begin
      @(negedge clk);
      it = q.pop_front();
      checks++;
      if (obs !== it.e) begin errors++; $display("FAIL clear_store step%0d: got %h want %h", k, obs, it.e); end
      mem_ready = it.mr; con_ff = it.cf; IR = it.ir; k++;
    end
    #2 clear = 1;
    #1 checks++;
    if (obs !== R) begin errors++; $display("FAIL clear_store_abort: got %h want %h", obs, R); end
    @(negedge clk);
    checks++;
    if (obs !== R) begin errors++; $display("FAIL clear_store_reset: got %h want %h", obs, R); end
    clear = 0;
    mem_ready = 1;
    @(negedge clk);
    checks++;
    if (obs !== F0) begin errors++; $display("FAIL clear_store_t0: got %h want %h", obs, F0); end
  endtask
  initial begin
    test_reset();
    test_add();
    test_fetch_stall();
    test_br();
    test_back_to_back();
    test_mul_illegal();
    test_ld_timeout();
    test_clear_store();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/control_unit.md
Name: control_unit

Overview:
- Moore-style control state machine that sequences the 32-bit register-bus datapath.
- Runs fetch / decode / execute. Drives every datapath strobe: register in/out enables, ALU op selects, Gra/Grb/Grc/Rin/Rout/BAout, memory read/write.
- Sits directly upstream of the datapath: consumes IR and con_ff from it, handshakes with memory through mem_ready.

Parameters:
- STALL_LIMIT, 15: max consecutive cycles a memory-wait state may see mem_ready=0 before halting with mem_err.

Ports:
- clk  input  1  system clock, rising edge.
- clear  input  1  asynchronous active-high reset.
- IR  input  32  instruction register; opcode IR[31:27].
- con_ff  input  1  branch-condition result from datapath, valid in BR_T3.
- mem_ready  input  1  memory completed current read/write.
- PCout, MDRout, HIout, LOout, Zhighout, Zlowout, Cout, BAout  output  1 each  bus source enables.
- PCin, IRin, MARin, Yin, HIin, LOin, Zin, MDRin  output  1 each  register load enables.
- Gra, Grb, Grc, Rin, Rout  output  1 each  register-field select/strobe.
- AND, OR, ADD, SUB, MUL, DIV, SHR, SHL, ROR, ROL, NEG, NOT, IncPC  output  1 each  ALU op selects.
- read, write  output  1 each  memory strobes.
- run  output  1  high while executing; low in HALT.
- mem_err  output  1  sticky, set on memory stall timeout.
- illegal_op  output  1  sticky, set on undefined opcode.

Behaviour:
- Reset: clear=1 asynchronously forces state RESET, stall counter 0, con latch 0.
  - All strobes 0, run=1, mem_err=0, illegal_op=0.
  - First clk edge after clear falls enters T0.
  - clear mid-instruction aborts it immediately; no partial strobes afterwards.
- Outputs are a pure function of the registered state (plus nothing else). The datapath samples them on the next rising edge.
- Fetch:
  - T0: PCout, MARin, IncPC, Zin.
  - T1: Zlowout, PCin, read, MDRin. Wait state.
  - T2: MDRout, IRin.
  - Next state is decode of IR[31:27].
- Wait-state rule (T1, LD_T6, ST_T7):
  - State holds while mem_ready=0; read/write and MDRin stay asserted.
  - Advances on the edge where mem_ready=1. mem_ready=1 on the first cycle means no stall.
  - Stall counter resets on entering a wait state and increments each held cycle.
  - When it reaches STALL_LIMIT with mem_ready still 0 → HALT, mem_err=1.
- Execute sequences (each returns to T0 after its last state):
  - add/sub/and/or/shr/shl/ror/rol (00011–01010):
    - T3: Grb Rout Yin.
    - T4: Grc Rout op Zin.
    - T5: Zlowout Gra Rin.
  - addi/andi/ori (01011–01101): as above, but T4 uses Cout instead of Grc Rout.
  - ld (00000):
    - T3: Grb BAout Yin.
    - T4: Cout ADD Zin.
    - T5: Zlowout MARin.
    - T6: read MDRin (wait).
    - T7: MDRout Gra Rin.
  - ldi (00001): T3 Grb BAout Yin; T4 Cout ADD Zin; T5 Zlowout Gra Rin.
  - st (00010):
    - T3–T5 as ld.
    - T6: Gra Rout MDRin (read=0).
    - T7: write (wait).
  - mul/div (01110/01111):
    - T3: Gra Rout Yin.
    - T4: Grb Rout MUL|DIV Zin.
    - T5: Zlowout LOin.
    - T6: Zhighout HIin.
  - neg/not (10000/10001): T3 Grb Rout NEG|NOT Zin; T4 Zlowout Gra Rin.
  - br (10010):
    - T3: Gra Rout; con latch ← con_ff at end of T3.
    - T4: PCout Yin.
    - T5: Cout ADD Zin.
    - T6: Zlowout PCin only if latch=1; otherwise no strobes.
  - jr (10011): T3 Gra Rout PCin.
  - mfhi (10111): T3 HIout Gra Rin. mflo (11000): T3 LOout Gra Rin.
  - nop (11001): straight to T0.
  - halt (11010): → HALT.
- Undefined opcode: → HALT, illegal_op=1.
- HALT: all strobes 0, run=0. Exit only via clear.
- Invariant checks: exactly one bus source enable asserted in any state that drives the bus; at most one ALU op asserted per cycle.

Test Plan:
- Release clear, IR=add R3,R1,R2 (0x19890000), mem_ready tied 1 → state walks RESET,T0,T1,T2,T3,T4,T5,T0; T4 shows Grc,Rout,ADD,Zin only; instruction takes 6 cycles from T0.
- Fetch with mem_ready low 3 cycles → T1 held 4 cycles with read=MDRin=1 throughout; T2 follows on the edge mem_ready=1.
- ld with mem_ready stuck 0 in LD_T6, STALL_LIMIT=15 → after 15 held cycles: HALT, run=0, mem_err=1, read drops to 0.
- br with con_ff=1 then con_ff=0 (each sampled at T3) → BR_T6 asserts Zlowout+PCin in the first case, no strobes in the second.
- mul R4,R5 → T5 Zlowout+LOin, T6 Zhighout+HIin, then T0; IR opcode 11111 → HALT with illegal_op=1.
- Assert clear during ST_T7 with write high → write and all strobes 0 in the same cycle; RESET, then T0 one edge after release.
